// File: rtl/irq_ctrl.sv
// Three-source interrupt controller: per-source sync + debounce + rising-edge latch,
// fixed-priority nested arbitration, registered request/ID/vector handed to the core.
module irq_ctrl #(
  parameter int          DB_CYCLES  = 16,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0300,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  btn_in,
  input  logic        int_en,
  input  logic        int_ack,
  input  logic        int_eret,
  output logic        int_req,
  output logic [1:0]  int_id,
  output logic [31:0] int_vec,
  output logic [2:0]  pending,
  output logic [2:0]  in_service
);
  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  logic [2:0]    s1, s2, db, db_nxt, rise;
  logic [CW-1:0] cnt     [3];
  logic [CW-1:0] cnt_nxt [3];
  logic [2:0]    allow, cand_bits, eret_clr, ack_set;
  logic          cand_vld, load, take;
  logic [1:0]    cand_id;

  // A level is accepted only after DB_CYCLES consecutive samples disagree with db.
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) db_nxt[i] = s2[i];
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  assign rise = db_nxt & ~db;

  // Only sources above the innermost active handler may interrupt it.
  always_comb begin
    allow = 3'b111;
    if (in_service[2])      allow = 3'b000;
    else if (in_service[1]) allow = 3'b100;
    else if (in_service[0]) allow = 3'b110;
  end

  assign cand_bits = pending & allow;
  assign cand_vld  = |cand_bits;
  assign cand_id   = cand_bits[2] ? 2'd2 : (cand_bits[1] ? 2'd1 : 2'd0);

  always_comb begin
    eret_clr = 3'b000;
    if (int_eret) begin
      if (in_service[2])      eret_clr = 3'b100;
      else if (in_service[1]) eret_clr = 3'b010;
      else if (in_service[0]) eret_clr = 3'b001;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (int_en && cand_vld) begin
          state_nxt = REQ;
          load      = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nxt = IDLE;
          take      = 1'b1;
        end else if (!int_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack_set = take ? (3'b001 << int_id) : 3'b000;
  assign int_req = (state == REQ);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ack clears pending before a same-edge rise sets it again, so the new event survives.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1         <= '0;
      s2         <= '0;
      db         <= '0;
      pending    <= '0;
      in_service <= '0;
      int_id     <= '0;
      int_vec    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1         <= btn_in;
      s2         <= s1;
      db         <= db_nxt;
      pending    <= (pending & ~ack_set) | rise;
      in_service <= (in_service & ~eret_clr) | ack_set;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
      if (load) begin
        int_id  <= cand_id;
        int_vec <= VEC_BASE + 32'(cand_id) * VEC_STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a history-window / handler-stack reference model.
module tb_irq_ctrl;
  localparam int DB = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  btn_in;
  logic        int_en, int_ack, int_eret;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vec;
  logic [2:0]  pending, in_service;

  irq_ctrl #(.DB_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .btn_in(btn_in), .int_en(int_en), .int_ack(int_ack),
    .int_eret(int_eret), .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
    .pending(pending), .in_service(in_service)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: raw-level history per source (bit j = level j edges ago),
  // debounced levels, pending set, presented request, and the handler stack.
  logic [31:0] hist [3];
  logic [2:0]  m_db, m_pend;
  logic [1:0]  m_stack[$];
  bit          m_req;
  logic [1:0]  m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    m_db = '0;
    m_pend = '0;
    m_stack.delete();
    m_req = 1'b0;
    m_id = '0;
  endtask

  function automatic logic [2:0] stack_bits();
    logic [2:0] b;
    b = '0;
    foreach (m_stack[k]) b[m_stack[k]] = 1'b1;
    return b;
  endfunction

  function automatic int cand();
    int top;
    top = (m_stack.size() == 0) ? -1 : int'(m_stack[m_stack.size()-1]);
    for (int i = 2; i >= 0; i--)
      if (m_pend[i] && i > top) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    chk("int_req", {31'd0, int_req}, {31'd0, m_req});
    chk("pending", {29'd0, pending}, {29'd0, m_pend});
    chk("in_service", {29'd0, in_service}, {29'd0, stack_bits()});
    if (m_req) begin
      chk("int_id", {30'd0, int_id}, {30'd0, m_id});
      chk("int_vec", int_vec, 32'h300 + 32'(m_id) * 32'h40);
    end
  endtask

  task automatic tick();
    logic [2:0] nd;
    int         c;
    bit         flip, push;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      nd = m_db;
      push = 1'b0;
      // A new level is accepted once the last DB synchronized samples all differ from it.
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][30:0], btn_in[i]};
        flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[i][j] == m_db[i]) flip = 1'b0;
        if (flip) nd[i] = ~m_db[i];
      end
      c = cand();
      if (m_req) begin
        if (int_ack) begin
          m_pend[m_id] = 1'b0;
          push = 1'b1;
          m_req = 1'b0;
        end else if (!int_en) begin
          m_req = 1'b0;
        end
      end else if (int_en && c >= 0) begin
        m_req = 1'b1;
        m_id = c[1:0];
      end
      if (int_eret && m_stack.size() > 0) void'(m_stack.pop_back());
      if (push) m_stack.push_back(m_id);
      m_pend = m_pend | (nd & ~m_db);
      m_db = nd;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    RST = 1'b1; btn_in = '0; int_en = 1'b0; int_ack = 1'b0; int_eret = 1'b0;
    model_reset();
    #1;
    chk("rst_req", {31'd0, int_req}, 32'd0);
    chk("rst_id", {30'd0, int_id}, 32'd0);
    chk("rst_vec", int_vec, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_in_service", {29'd0, in_service}, 32'd0);
    tick(); tick();
    RST = 1'b0;
    int_en = 1'b1;
    tick(); tick();

    // Basic request on source 1
    btn_in[1] = 1'b1;
    repeat (6) tick();
    chk("basic_pend_e5", {29'd0, pending}, 32'b010);
    chk("basic_noreq_e5", {31'd0, int_req}, 32'd0);
    tick();
    chk("basic_req_e6", {31'd0, int_req}, 32'd1);
    chk("basic_id", {30'd0, int_id}, 32'd1);
    chk("basic_vec", int_vec, 32'h340);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("basic_ack_pend", {29'd0, pending}, 32'b000);
    chk("basic_ack_is", {29'd0, in_service}, 32'b010);
    chk("basic_ack_req", {31'd0, int_req}, 32'd0);
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    chk("basic_eret_is", {29'd0, in_service}, 32'b000);
    btn_in[1] = 1'b0;
    repeat (8) tick();

    // Glitch shorter than the debounce window
    btn_in[0] = 1'b1;
    repeat (3) tick();
    btn_in[0] = 1'b0;
    repeat (8) tick();
    chk("glitch_pend", {29'd0, pending}, 32'b000);
    chk("glitch_req", {31'd0, int_req}, 32'd0);

    // Priority and nesting
    btn_in = 3'b101;
    repeat (7) tick();
    chk("prio_req", {31'd0, int_req}, 32'd1);
    chk("prio_id", {30'd0, int_id}, 32'd2);
    chk("prio_vec", int_vec, 32'h380);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("prio_ack_is", {29'd0, in_service}, 32'b100);
    chk("prio_ack_pend", {29'd0, pending}, 32'b001);
    btn_in[2] = 1'b0;
    repeat (6) tick();
    chk("src0_blocked", {31'd0, int_req}, 32'd0);
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    chk("eret_edge_noreq", {31'd0, int_req}, 32'd0);
    tick();
    chk("src0_req", {31'd0, int_req}, 32'd1);
    chk("src0_vec", int_vec, 32'h300);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("src0_is", {29'd0, in_service}, 32'b001);
    btn_in[1] = 1'b1;
    repeat (7) tick();
    chk("nest_req", {31'd0, int_req}, 32'd1);
    chk("nest_id", {30'd0, int_id}, 32'd1);
    chk("nest_is", {29'd0, in_service}, 32'b001);

    // Enable gating and withdrawal
    int_en = 1'b0; tick();
    chk("withdraw_req", {31'd0, int_req}, 32'd0);
    chk("withdraw_pend", {29'd0, pending}, 32'b010);
    repeat (3) tick();
    chk("gated_req", {31'd0, int_req}, 32'd0);
    int_en = 1'b1; tick();
    chk("reen_req", {31'd0, int_req}, 32'd1);
    chk("reen_id", {30'd0, int_id}, 32'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("nest_ack_is", {29'd0, in_service}, 32'b011);
    int_eret = 1'b1; tick(); int_eret = 1'b0;
    chk("nest_eret_is", {29'd0, in_service}, 32'b001);

    // Ack and eret on the same edge
    btn_in[2] = 1'b1;
    repeat (7) tick();
    chk("simul_id", {30'd0, int_id}, 32'd2);
    int_ack = 1'b1; int_eret = 1'b1; tick(); int_ack = 1'b0; int_eret = 1'b0;
    chk("simul_is", {29'd0, in_service}, 32'b100);
    int_eret = 1'b1; tick(); int_eret = 1'b0;

    // Reset while a request is presented
    btn_in = '0;
    repeat (8) tick();
    btn_in[0] = 1'b1;
    repeat (7) tick();
    chk("prerst_req", {31'd0, int_req}, 32'd1);
    RST = 1'b1;
    model_reset();
    #1;
    chk("midrst_req", {31'd0, int_req}, 32'd0);
    chk("midrst_vec", int_vec, 32'd0);
    chk("midrst_pend", {29'd0, pending}, 32'd0);
    chk("midrst_is", {29'd0, in_service}, 32'd0);
    tick();
    RST = 1'b0;
    repeat (5) tick();
    chk("postrst_pend", {29'd0, pending}, 32'd0);
    chk("postrst_noreq", {31'd0, int_req}, 32'd0);
    repeat (2) tick();
    chk("postrst_req", {31'd0, int_req}, 32'd1);
    chk("postrst_id", {30'd0, int_id}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
      int_en   = ($urandom_range(0, 15) != 0);
      int_ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      int_eret = ($urandom_range(0, 9) == 0);
      RST      = (n == 1500);
      tick();
    end
    RST = 1'b0; int_ack = 1'b0; int_eret = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
